// File: rtl/rfft_4pt_ctrl.sv
// Sequencing controller for the 4-point radix-2 DIT FFT datapath (rfft_4pt + pe).
// Optional conjugate-twiddle (IFFT) support is enabled by defining RFFT_CTRL_IFFT_EN.
module rfft_4pt_ctrl #(
  parameter int PE_LAT = 1,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef RFFT_CTRL_IFFT_EN
  input  logic             inv,
`endif
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             m0,
  output logic             m11,
  output logic [1:0]       m12,
  output logic [1:0]       m13,
  output logic             m14,
  output logic             m21,
  output logic             m22,
  output logic             m23,
  output logic             m24,
  output logic [15:0]      w_r,
  output logic [15:0]      w_i,
  output logic             en
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_STG1,
    S_STG2A,
    S_STG2B,
    S_DONE
  } state_t;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        en;
    logic        m0;
    logic        m11;
    logic [1:0]  m12;
    logic [1:0]  m13;
    logic        m14;
    logic        m21;
    logic        m22;
    logic        m23;
    logic        m24;
    logic [15:0] w_r;
    logic [15:0] w_i;
  } ctrl_t;

  localparam logic [3:0] CNT_LOAD = 4'(PE_LAT - 1);

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             inv_q, inv_d;
  logic             inv_in;
  ctrl_t            ctrl_q, ctrl_d;

`ifdef RFFT_CTRL_IFFT_EN
  assign inv_in = inv;
`else
  assign inv_in = 1'b0;
`endif

  // Next state: stages advance on terminal count; start is only honoured in IDLE/DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    frame_cnt_d = frame_cnt_q;
    inv_d       = inv_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_STG1;
          cnt_d   = CNT_LOAD;
          inv_d   = inv_in;
        end
      end
      S_STG1: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STG2A;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STG2A: begin
        if (cnt_q == 4'd0) begin
          state_d = S_STG2B;
          cnt_d   = CNT_LOAD;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_STG2B: begin
        if (cnt_q == 4'd0) begin
          state_d     = S_DONE;
          cnt_d       = 4'd0;
          frame_cnt_d = frame_cnt_q + CNT_W'(1);
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        if (start) begin
          state_d = S_STG1;
          cnt_d   = CNT_LOAD;
          inv_d   = inv_in;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase
  end

  // Control word decoded from the next state so the registered outputs line up with state_q.
  always_comb begin
    ctrl_d = '0;
    case (state_d)
      S_STG1: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.en   = 1'b1;
        ctrl_d.m12  = 2'd2;
        ctrl_d.m13  = 2'd1;
        ctrl_d.m14  = 1'b1;
        ctrl_d.m23  = 1'b1;
        ctrl_d.m24  = 1'b1;
        ctrl_d.w_r  = 16'h7FFF;
      end
      S_STG2A: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.en   = 1'b1;
        ctrl_d.m0   = 1'b1;
        ctrl_d.m12  = 2'd1;
        ctrl_d.m13  = 2'd2;
        ctrl_d.m14  = 1'b1;
        ctrl_d.m22  = 1'b1;
        ctrl_d.m23  = 1'b1;
        ctrl_d.w_r  = 16'h7FFF;
      end
      S_STG2B: begin
        ctrl_d.busy = 1'b1;
        ctrl_d.en   = 1'b1;
        ctrl_d.m0   = 1'b1;
        ctrl_d.m12  = 2'd1;
        ctrl_d.m13  = 2'd2;
        ctrl_d.m14  = 1'b1;
        ctrl_d.m22  = 1'b1;
        ctrl_d.m23  = 1'b1;
        ctrl_d.w_i  = inv_d ? 16'h7FFF : 16'h8001;
      end
      S_DONE: begin
        ctrl_d.done = 1'b1;
      end
      default: begin
        ctrl_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      frame_cnt_q <= '0;
      inv_q       <= 1'b0;
      ctrl_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      frame_cnt_q <= frame_cnt_d;
      inv_q       <= inv_d;
      ctrl_q      <= ctrl_d;
    end
  end

  assign busy      = ctrl_q.busy;
  assign done      = ctrl_q.done;
  assign en        = ctrl_q.en;
  assign m0        = ctrl_q.m0;
  assign m11       = ctrl_q.m11;
  assign m12       = ctrl_q.m12;
  assign m13       = ctrl_q.m13;
  assign m14       = ctrl_q.m14;
  assign m21       = ctrl_q.m21;
  assign m22       = ctrl_q.m22;
  assign m23       = ctrl_q.m23;
  assign m24       = ctrl_q.m24;
  assign w_r       = ctrl_q.w_r;
  assign w_i       = ctrl_q.w_i;
  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_rfft_4pt_ctrl.sv
// Bench for rfft_4pt_ctrl: three instances (PE_LAT=1, PE_LAT=3, CNT_W=2) checked every cycle
// against a transform-position model, plus directed tables and corner-case sequences.
module tb_rfft_4pt_ctrl;

`ifdef RFFT_CTRL_IFFT_EN
  localparam bit IFFT = 1'b1;
`else
  localparam bit IFFT = 1'b0;
`endif

  // Observed word layout: {busy,done,en,m0,m11,m12,m13,m14,m21,m22,m23,m24,w_r,w_i}
  localparam logic [45:0] W_STG1 = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 2'd2, 2'd1, 1'b1,
                                    1'b0, 1'b0, 1'b1, 1'b1, 16'h7FFF, 16'h0000};
  localparam logic [45:0] W_STG2A = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1,
                                     1'b0, 1'b1, 1'b1, 1'b0, 16'h7FFF, 16'h0000};
  localparam logic [45:0] W_STG2B_F = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1,
                                       1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h8001};
  localparam logic [45:0] W_STG2B_I = {1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'd1, 2'd2, 1'b1,
                                       1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 16'h7FFF};
  localparam logic [45:0] W_DONE = {1'b0, 1'b1, 44'd0};
  localparam int BIT_DONE = 44;
  localparam int BIT_EN   = 43;

  logic        clk;
  logic        rst;
  logic [2:0]  start;
  logic [2:0]  inv;
  logic [45:0] obs  [3];
  logic [7:0]  fcnt [3];

  int n_chk;
  int n_fail;

  // Reference model: position within the current transform (-1 idle, 3*L = DONE cycle).
  int pos     [3];
  int frame   [3];
  bit inv_l   [3];
  int lat_of  [3];
  int mask_of [3];

  typedef struct {
    logic        start;
    logic [45:0] word;
    logic [7:0]  fc;
  } vec_t;
  vec_t tbl[5];

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUTs ----------------
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int L  = (g == 1) ? 3 : 1;
    localparam int CW = (g == 2) ? 2 : 8;
    logic          busy, done, en, m0, m11, m14, m21, m22, m23, m24;
    logic [1:0]    m12, m13;
    logic [15:0]   w_r, w_i;
    logic [CW-1:0] fc;

    rfft_4pt_ctrl #(.PE_LAT(L), .CNT_W(CW)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start[g]),
`ifdef RFFT_CTRL_IFFT_EN
      .inv       (inv[g]),
`endif
      .busy      (busy),
      .done      (done),
      .frame_cnt (fc),
      .m0        (m0),
      .m11       (m11),
      .m12       (m12),
      .m13       (m13),
      .m14       (m14),
      .m21       (m21),
      .m22       (m22),
      .m23       (m23),
      .m24       (m24),
      .w_r       (w_r),
      .w_i       (w_i),
      .en        (en)
    );

    assign obs[g]  = {busy, done, en, m0, m11, m12, m13, m14, m21, m22, m23, m24, w_r, w_i};
    assign fcnt[g] = 8'(fc);
  end

  // ---------------- model ----------------
  function automatic logic [45:0] exp_word(int p, int l, bit iv);
    logic [45:0] w;
    w = '0;
    if (p >= 0 && p < 3 * l) begin
      case (p / l)
        0:       w = W_STG1;
        1:       w = W_STG2A;
        default: w = iv ? W_STG2B_I : W_STG2B_F;
      endcase
    end else if (p == 3 * l) begin
      w = W_DONE;
    end
    return w;
  endfunction

  task automatic model_step(int g);
    if (rst) begin
      pos[g]   = -1;
      frame[g] = 0;
    end else if (pos[g] == -1 || pos[g] == 3 * lat_of[g]) begin
      if (start[g]) begin
        pos[g]   = 0;
        inv_l[g] = IFFT ? inv[g] : 1'b0;
      end else begin
        pos[g] = -1;
      end
    end else begin
      pos[g] = pos[g] + 1;
      if (pos[g] == 3 * lat_of[g]) frame[g] = (frame[g] + 1) & mask_of[g];
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t actual=%h required=%h", name, $time, act, exp);
    end
  endtask

  // One clock: advance the model on the edge, compare all instances 1ns later.
  task automatic tick();
    @(posedge clk);
    for (int g = 0; g < 3; g++) model_step(g);
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("word[%0d]", g), 64'(obs[g]), 64'(exp_word(pos[g], lat_of[g], inv_l[g])));
      chk($sformatf("frame_cnt[%0d]", g), 64'(fcnt[g]), 64'(frame[g]));
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int done_cnt;
    int en_cnt;
    int done_at;
    int first_done;
    int last_done;
    int f0;
    int exp_fc[5];

    n_chk   = 0;
    n_fail  = 0;
    lat_of  = '{1, 3, 1};
    mask_of = '{255, 255, 3};
    for (int g = 0; g < 3; g++) begin
      pos[g]   = -1;
      frame[g] = 0;
      inv_l[g] = 1'b0;
    end
    exp_fc = '{1, 2, 3, 0, 1};

    tbl[0] = '{start: 1'b1, word: W_STG1,    fc: 8'd0};
    tbl[1] = '{start: 1'b0, word: W_STG2A,   fc: 8'd0};
    tbl[2] = '{start: 1'b0, word: W_STG2B_F, fc: 8'd0};
    tbl[3] = '{start: 1'b0, word: W_DONE,    fc: 8'd1};
    tbl[4] = '{start: 1'b0, word: 46'd0,     fc: 8'd1};

    rst   = 1'b1;
    start = 3'b000;
    inv   = 3'b000;
    #1;
    for (int g = 0; g < 3; g++) chk("reset_word", 64'(obs[g]), 64'd0);
    repeat (2) tick();
    rst = 1'b0;
    tick();

    // Single PE_LAT=1 transform, cycle by cycle from the table.
    for (int i = 0; i < 5; i++) begin
      start[0] = tbl[i].start;
      tick();
      chk($sformatf("tbl_word[%0d]", i), 64'(obs[0]), 64'(tbl[i].word));
      chk($sformatf("tbl_fc[%0d]", i), 64'(fcnt[0]), 64'(tbl[i].fc));
    end

    // PE_LAT=3: nine enable cycles, done in cycle 10.
    en_cnt  = 0;
    done_at = -1;
    start[1] = 1'b1;
    for (int c = 1; c <= 13; c++) begin
      tick();
      start[1] = 1'b0;
      if (obs[1][BIT_EN]) en_cnt++;
      if (obs[1][BIT_DONE]) done_at = c;
    end
    chk("lat3_en_cycles", 64'(en_cnt), 64'd9);
    chk("lat3_done_cycle", 64'(done_at), 64'd10);

    // start held high: back-to-back transforms, done every 4 cycles.
    done_cnt   = 0;
    first_done = -1;
    last_done  = -1;
    start[0]   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      tick();
      if (obs[0][BIT_DONE]) begin
        done_cnt++;
        if (first_done < 0) first_done = c;
        last_done = c;
      end
    end
    start[0] = 1'b0;
    chk("b2b_done_count", 64'(done_cnt), 64'd4);
    chk("b2b_first_done", 64'(first_done), 64'd4);
    chk("b2b_done_span", 64'(last_done - first_done), 64'd12);
    repeat (3) tick();

    // start pulses while busy (sampled in STG1 and STG2B) are ignored.
    f0       = int'(fcnt[0]);
    done_cnt = 0;
    for (int c = 0; c < 8; c++) begin
      start[0] = (c == 0 || c == 1 || c == 3);
      tick();
      if (obs[0][BIT_DONE]) done_cnt++;
    end
    start[0] = 1'b0;
    chk("busy_start_dones", 64'(done_cnt), 64'd1);
    chk("busy_start_frame", 64'(fcnt[0]), 64'((f0 + 1) & 255));

    // CNT_W=2 frame counter wraps 3 -> 0.
    for (int t = 0; t < 5; t++) begin
      start[2] = 1'b1;
      tick();
      start[2] = 1'b0;
      repeat (3) tick();
      chk($sformatf("wrap_done[%0d]", t), 64'(obs[2][BIT_DONE]), 64'd1);
      chk($sformatf("wrap_fc[%0d]", t), 64'(fcnt[2]), 64'(exp_fc[t]));
      tick();
    end

`ifdef RFFT_CTRL_IFFT_EN
    // Conjugate twiddle in STG2B with inv=1.
    start[0] = 1'b1;
    inv[0]   = 1'b1;
    tick();
    start[0] = 1'b0;
    inv[0]   = 1'b0;
    repeat (2) tick();
    chk("ifft_stg2b_wi", 64'(obs[0][15:0]), 64'h7FFF);
    repeat (3) tick();
`endif

    // Asynchronous reset in the middle of STG2A of the PE_LAT=3 instance.
    start[1] = 1'b1;
    tick();
    start[1] = 1'b0;
    repeat (4) tick();
    chk("pre_reset_in_stg2a", 64'(obs[1]), 64'(W_STG2A));
    #3;
    rst = 1'b1;
    #1;
    for (int g = 0; g < 3; g++) begin
      chk($sformatf("async_rst_word[%0d]", g), 64'(obs[g]), 64'd0);
      chk($sformatf("async_rst_fc[%0d]", g), 64'(fcnt[g]), 64'd0);
    end
    tick();
    rst = 1'b0;
    repeat (3) tick();

    // Randomized start/inv traffic on all instances.
    for (int c = 0; c < 600; c++) begin
      for (int g = 0; g < 3; g++) begin
        start[g] = ($urandom_range(0, 3) == 0);
        inv[g]   = $urandom_range(0, 1) == 1;
      end
      tick();
    end
    start = 3'b000;
    repeat (15) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
